// File: rtl/game_flow_ctrl.sv
// Game sequencer: frame tick, IDLE/SERVE/PLAY/MISS/OVER flow, score/lives and border flash.
// All outputs are flops; next values are derived from the next state.
module game_flow_ctrl #(
    parameter logic [10:0] FRAME_TICK_LINE = 11'd480,
    parameter logic [1:0]  LIVES_INIT      = 2'd3,
    parameter logic [7:0]  SERVE_FRAMES    = 8'd60,
    parameter logic [7:0]  MISS_FRAMES     = 8'd90,
    parameter logic [7:0]  FLASH_FRAMES    = 8'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        btn_start,
    input  logic        ball_hit,
    input  logic        ball_miss,
    output logic        ball_run,
    output logic        ball_respawn,
    output logic        border_en,
    output logic [7:0]  score,
    output logic [1:0]  lives,
    output logic        game_over,
    output logic        frame_tick
);

    typedef enum logic [2:0] {StIdle, StServe, StPlay, StMiss, StOver} state_e;

    state_e     state_q, state_d;
    logic       start_q, start_edge;
    logic       tick_q;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] flash_cnt_q, flash_cnt_d;
    logic [7:0] score_q, score_d;
    logic [1:0] lives_q, lives_d;
    logic       border_q, border_d;
    logic       run_q, run_d;
    logic       respawn_q, respawn_d;
    logic       over_q, over_d;

    assign start_edge = btn_start & ~start_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            tick_q      <= 1'b0;
            frame_cnt_q <= 8'd0;
            flash_cnt_q <= 8'd0;
            score_q     <= 8'd0;
            lives_q     <= LIVES_INIT;
            border_q    <= 1'b1;
            run_q       <= 1'b0;
            respawn_q   <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= btn_start;
            tick_q      <= (hcount == 11'd0) && (vcount == FRAME_TICK_LINE);
            frame_cnt_q <= frame_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            border_q    <= border_d;
            run_q       <= run_d;
            respawn_q   <= respawn_d;
            over_q      <= over_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        flash_cnt_d = flash_cnt_q;
        score_d     = score_q;
        lives_d     = lives_q;
        border_d    = border_q;
        case (state_q)
            StIdle, StOver: begin
                border_d = 1'b1;
                if (start_edge) begin
                    score_d     = 8'd0;
                    lives_d     = LIVES_INIT;
                    frame_cnt_d = 8'd0;
                    flash_cnt_d = 8'd0;
                    state_d     = StServe;
                end
            end
            StServe: begin
                border_d = 1'b1;
                if (tick_q) begin
                    if (frame_cnt_q == SERVE_FRAMES - 8'd1) begin
                        frame_cnt_d = 8'd0;
                        state_d     = StPlay;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            StPlay: begin
                // A miss wins over a simultaneous hit.
                if (ball_miss) begin
                    lives_d     = lives_q - 2'd1;
                    frame_cnt_d = 8'd0;
                    flash_cnt_d = 8'd0;
                    border_d    = 1'b0;
                    state_d     = StMiss;
                end else if (ball_hit && score_q != 8'd255) begin
                    score_d = score_q + 8'd1;
                end
            end
            StMiss: begin
                if (tick_q) begin
                    if (flash_cnt_q == FLASH_FRAMES - 8'd1) begin
                        flash_cnt_d = 8'd0;
                        border_d    = ~border_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 8'd1;
                    end
                    if (frame_cnt_q == MISS_FRAMES - 8'd1) begin
                        frame_cnt_d = 8'd0;
                        flash_cnt_d = 8'd0;
                        border_d    = 1'b1;
                        state_d     = (lives_q == 2'd0) ? StOver : StServe;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        run_d     = (state_d == StPlay);
        respawn_d = (state_d == StServe) && (state_q != StServe);
        over_d    = (state_d == StOver);
    end

    assign ball_run     = run_q;
    assign ball_respawn = respawn_q;
    assign border_en    = border_q;
    assign score        = score_q;
    assign lives        = lives_q;
    assign game_over    = over_q;
    assign frame_tick   = tick_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl using a shortened 4x2-line frame (8 cycles per frame tick).
module tb_game_flow_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hcount = 11'd0;
    logic [10:0] vcount = 11'd479;
    logic        btn_start = 1'b0;
    logic        ball_hit = 1'b0;
    logic        ball_miss = 1'b0;
    logic        ball_run, ball_respawn, border_en, game_over, frame_tick;
    logic [7:0]  score;
    logic [1:0]  lives;

    int checks = 0;
    int errors = 0;

    game_flow_ctrl dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .btn_start(btn_start), .ball_hit(ball_hit), .ball_miss(ball_miss),
        .ball_run(ball_run), .ball_respawn(ball_respawn), .border_en(border_en),
        .score(score), .lives(lives), .game_over(game_over), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Tiny raster: hcount 0..3, vcount alternates 479/480; settles 2 ns after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            hcount = (hcount == 11'd3) ? 11'd0 : hcount + 11'd1;
            if (hcount == 11'd0) vcount = (vcount == 11'd480) ? 11'd479 : 11'd480;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_hit();
        ball_hit = 1'b1;
        @(negedge clk);
        ball_hit = 1'b0;
        @(negedge clk);
    endtask

    // sel: 0 = ball_run, 1 = ball_respawn, 2 = game_over
    task automatic wait_for(input string tag, input int sel);
        int g = 0;
        while (g < 3000 && !(sel == 0 ? ball_run : (sel == 1 ? ball_respawn : game_over))) begin
            @(negedge clk);
            g++;
        end
        chk(tag, 32'(g < 3000), 32'd1);
    endtask

    initial begin
        int ticks, bad, respawns, rises, ticks_at_rise, prev_tick_at_rise, k, g;
        logic prev_tick, prev_run, counting;

        // Reset state
        cyc(3);
        chk("rst_border", 32'(border_en), 32'd1);
        chk("rst_run", 32'(ball_run), 32'd0);
        chk("rst_respawn", 32'(ball_respawn), 32'd0);
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_over", 32'(game_over), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        reset = 1'b0;

        // Idle for two frames
        cyc(8);
        ticks = 0; bad = 0; prev_tick = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                ticks++;
                if (prev_tick || hcount != 11'd1 || vcount != 11'd480) bad++;
            end
            if (ball_run || !border_en) bad++;
            prev_tick = frame_tick;
        end
        chk("idle_ticks", 32'(ticks), 32'd2);
        chk("idle_tick_shape", 32'(bad), 32'd0);

        // Start held for 1000 cycles
        btn_start = 1'b1;
        respawns = 0; rises = 0; ticks = 0; ticks_at_rise = 0; prev_tick_at_rise = 0;
        prev_tick = 1'b0; prev_run = 1'b0; counting = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ball_respawn) begin respawns++; counting = 1'b1; end
            if (counting && frame_tick && !ball_run) ticks++;
            if (ball_run && !prev_run) begin
                rises++;
                ticks_at_rise = ticks;
                prev_tick_at_rise = int'(prev_tick);
            end
            prev_tick = frame_tick;
            prev_run = ball_run;
        end
        btn_start = 1'b0;
        chk("hold_respawns", 32'(respawns), 32'd1);
        chk("hold_run_rises", 32'(rises), 32'd1);
        chk("serve_ticks", 32'(ticks_at_rise), 32'd60);
        chk("run_after_tick", 32'(prev_tick_at_rise), 32'd1);

        // Three hits then a miss, follow the border flash
        repeat (3) pulse_hit();
        chk("score_3", 32'(score), 32'd3);
        ball_miss = 1'b1;
        @(negedge clk);
        ball_miss = 1'b0;
        chk("miss_lives", 32'(lives), 32'd2);
        chk("miss_border", 32'(border_en), 32'd0);
        chk("miss_run", 32'(ball_run), 32'd0);
        chk("miss_score", 32'(score), 32'd3);
        k = 0; g = 0; bad = 0;
        while (k < 90 && g < 2000) begin
            if (frame_tick) begin
                k++;
                if (border_en !== 1'(((k - 1) / 10) % 2)) bad++;
            end
            if (k < 90) begin
                @(negedge clk);
                g++;
            end
        end
        chk("miss_tick_count", 32'(k), 32'd90);
        chk("flash_pattern", 32'(bad), 32'd0);
        @(negedge clk);
        chk("miss_end_border", 32'(border_en), 32'd1);
        chk("reserve_respawn", 32'(ball_respawn), 32'd1);
        chk("reserve_run", 32'(ball_run), 32'd0);
        @(negedge clk);
        chk("respawn_one_cycle", 32'(ball_respawn), 32'd0);

        // Simultaneous hit and miss at score 5
        wait_for("play2", 0);
        repeat (2) pulse_hit();
        chk("score_5", 32'(score), 32'd5);
        ball_hit = 1'b1; ball_miss = 1'b1;
        @(negedge clk);
        ball_hit = 1'b0; ball_miss = 1'b0;
        chk("both_score", 32'(score), 32'd5);
        chk("both_lives", 32'(lives), 32'd1);
        chk("both_border", 32'(border_en), 32'd0);
        chk("both_run", 32'(ball_run), 32'd0);
        wait_for("serve3", 1);

        // Start ignored in PLAY, then saturation
        wait_for("play3", 0);
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        chk("start_in_play_respawn", 32'(ball_respawn), 32'd0);
        chk("start_in_play_run", 32'(ball_run), 32'd1);
        repeat (245) pulse_hit();
        chk("score_250", 32'(score), 32'd250);
        repeat (256) pulse_hit();
        chk("score_sat", 32'(score), 32'd255);

        // Third miss leads to OVER
        ball_miss = 1'b1;
        @(negedge clk);
        ball_miss = 1'b0;
        chk("miss3_lives", 32'(lives), 32'd0);
        chk("miss3_over_early", 32'(game_over), 32'd0);
        wait_for("over", 2);
        chk("over_lives", 32'(lives), 32'd0);
        chk("over_score", 32'(score), 32'd255);
        chk("over_border", 32'(border_en), 32'd1);
        chk("over_run", 32'(ball_run), 32'd0);
        pulse_hit();
        chk("over_hit_ignored", 32'(score), 32'd255);
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_lives", 32'(lives), 32'd3);
        chk("restart_over", 32'(game_over), 32'd0);
        chk("restart_respawn", 32'(ball_respawn), 32'd1);
        pulse_hit();
        chk("serve_hit_ignored", 32'(score), 32'd0);

        // Reset in the middle of MISS
        wait_for("play4", 0);
        ball_miss = 1'b1;
        @(negedge clk);
        ball_miss = 1'b0;
        cyc(5);
        chk("premrst_border", 32'(border_en), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_border", 32'(border_en), 32'd1);
        chk("mrst_run", 32'(ball_run), 32'd0);
        chk("mrst_lives", 32'(lives), 32'd3);
        chk("mrst_over", 32'(game_over), 32'd0);
        chk("mrst_tick", 32'(frame_tick), 32'd0);
        reset = 1'b0;
        respawns = 0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ball_respawn) respawns++;
            if (ball_run || !border_en) bad++;
        end
        chk("post_rst_idle", 32'(bad), 32'd0);
        chk("post_rst_no_serve", 32'(respawns), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
